ahb_scratchpad_sub: RTL and testbench

// AHB-Lite subordinate (responder) scratchpad memory: the receiving end of the manager bus driven
// by the core's bus interface unit. Sits behind the uncore address decoder/mux. Provides

---
 rtl/ahb_scratchpad_sub.sv | 145 ++++++++++++++
 tb/tb_ahb_scratchpad_sub.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_scratchpad_sub.sv
// AHB-Lite subordinate scratchpad: flop word store with byte strobes,
// programmable wait states and two-cycle ERROR responses.
module ahb_scratchpad_sub #(
  parameter int PA_BITS = 32,
  parameter int AHBW    = 64,
  parameter int AW      = 8,
  parameter int WAITS   = 0,
  parameter bit RO      = 1'b0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [PA_BITS-1:0] HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [AHBW-1:0]    HWDATA,
  input  logic [AHBW/8-1:0]  HWSTRB,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [AHBW-1:0]    HRDATA
);

  localparam int NB    = AHBW / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  localparam logic [3:0] WAIT_INIT =
    (WAITS > 0) ? 4'(WAITS - 1) : 4'd0;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rdy_q, rdy_d;
  logic          resp_q, resp_d;

  logic [AHBW-1:0] mem_q [DEPTH];

  logic       accept;
  logic       size_bad;
  logic       misalign;
  logic       wr_bad;
  logic       illegal;
  logic [7:0] amask;
  logic       do_wr;
  logic       do_rd;
  logic       unused_ok;

  assign accept   = HSEL & HTRANS[1] & HREADY;
  assign size_bad = HSIZE > 3'(LB);
  assign amask    = ~(8'hFF << HSIZE);
  assign misalign = |(HADDR[7:0] & amask);
  assign wr_bad   = HWRITE & RO;
  assign illegal  = size_bad | misalign | wr_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        // IDLE and ERR2 both close any data phase and may accept
        state_d = S_IDLE;
        vld_d   = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = S_ERR1;
          end else begin
            vld_d = 1'b1;
            wr_d  = HWRITE;
            idx_d = HADDR[AW+LB-1:LB];
            if (WAITS > 0) begin
              state_d = S_WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
    endcase
  end

  assign rdy_d  = (state_d == S_IDLE) | (state_d == S_ERR2);
  assign resp_d = (state_d == S_ERR1) | (state_d == S_ERR2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      rdy_q   <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      resp_q  <= resp_d;
    end
  end

  assign do_wr = vld_q & wr_q & rdy_q;
  assign do_rd = vld_q & ~wr_q & rdy_q;

  // storage is deliberately unreset; reset drops vld_q so no write lands
  always_ff @(posedge HCLK) begin
    if (do_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (HWSTRB[b]) begin
          mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HREADYOUT = rdy_q;
  assign HRESP     = resp_q;
  assign HRDATA    = do_rd ? mem_q[idx_q] : '0;

  assign unused_ok = ^{HADDR, HTRANS[0]};

endmodule

// File: tb/tb_ahb_scratchpad_sub.sv
// Bench for ahb_scratchpad_sub: three configurations driven by a
// pipelined manager and compared against a byte-level memory model.
module tb_ahb_scratchpad_sub;

  localparam int AW  = 4;
  localparam int NW  = 1 << AW;
  localparam int NBY = NW * 8;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [63:0] hwdata = '0;
  logic [7:0]  hwstrb = '0;
  logic [2:0]  hsel = '0;
  logic [2:0]  rdy_a;
  logic [2:0]  resp_a;
  logic [63:0] rdata_a [3];
  logic        hready;
  int          cur = 0;

  always #5 HCLK = ~HCLK;

  assign hready = rdy_a[cur];

  ahb_scratchpad_sub #(.AHBW(64), .AW(AW), .WAITS(0), .RO(1'b0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADY(hready), .HREADYOUT(rdy_a[0]),
    .HRESP(resp_a[0]), .HRDATA(rdata_a[0])
  );

  ahb_scratchpad_sub #(.AHBW(64), .AW(AW), .WAITS(3), .RO(1'b0)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADY(hready), .HREADYOUT(rdy_a[1]),
    .HRESP(resp_a[1]), .HRDATA(rdata_a[1])
  );

  ahb_scratchpad_sub #(.AHBW(64), .AW(AW), .WAITS(0), .RO(1'b1)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADY(hready), .HREADYOUT(rdy_a[2]),
    .HRESP(resp_a[2]), .HRDATA(rdata_a[2])
  );

  typedef struct {
    bit          idle;
    bit          sel;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } xfer_t;

  int checks = 0;
  int fails  = 0;

  int waits_of [3] = '{0, 3, 0};
  bit ro_of    [3] = '{1'b0, 1'b0, 1'b1};

  logic [7:0] mdl   [3][NBY];
  bit         known [3][NBY];

  xfer_t       q [$];
  logic [63:0] cap_rdata [$];
  int          cap_waits [$];
  bit          cap_resp  [$];

  function automatic xfer_t mk(bit wr, logic [31:0] a, logic [2:0] sz,
                               logic [63:0] d, logic [7:0] s);
    xfer_t t;
    t.idle  = 1'b0;
    t.sel   = 1'b1;
    t.addr  = a;
    t.wr    = wr;
    t.size  = sz;
    t.wdata = d;
    t.strb  = s;
    return t;
  endfunction

  function automatic bit is_err(int d, xfer_t t);
    int nb;
    nb = 1 << t.size;
    return (t.size > 3) || ((t.addr % nb) != 0) || (t.wr && ro_of[d]);
  endfunction

  function automatic int wbase(logic [31:0] a);
    return ((a >> 3) % NW) * 8;
  endfunction

  // pipelined manager; each completed data phase is checked and captured
  task automatic run_seq();
    int    ai = 0;
    int    n;
    int    budget;
    int    wcnt = 0;
    bit    last_ready = 1'b1;
    bit    ap = 1'b0;
    bit    dp = 1'b0;
    bit    fin = 1'b0;
    bit    e;
    bit    rdy;
    bit    rsp;
    logic [63:0] rd;
    logic [63:0] exp;
    logic [63:0] msk;
    xfer_t dx;
    xfer_t ax;
    int    bb;
    n = q.size();
    budget = n * 25 + 20;
    cap_rdata.delete();
    cap_waits.delete();
    cap_resp.delete();
    while (budget > 0 && !fin) begin
      @(posedge HCLK);
      #1;
      budget--;
      if (last_ready) begin
        dp = ap;
        dx = ax;
        wcnt = 0;
      end
      rdy = rdy_a[cur];
      rsp = resp_a[cur];
      rd  = rdata_a[cur];
      if (dp) begin
        e = is_err(cur, dx);
        if (!rdy) begin
          wcnt++;
          checks++;
          if (rsp !== e || rd !== 64'd0) begin
            fails++;
            $display("FAIL wait_cycle dut%0d a=%h: resp=%b rdata=%h need resp=%b rdata=0",
                     cur, dx.addr, rsp, rd, e);
          end
        end else begin
          checks++;
          if (wcnt != (e ? 1 : waits_of[cur])) begin
            fails++;
            $display("FAIL latency dut%0d a=%h: waits=%0d need %0d",
                     cur, dx.addr, wcnt, e ? 1 : waits_of[cur]);
          end
          checks++;
          if (rsp !== e) begin
            fails++;
            $display("FAIL resp dut%0d a=%h: got %b need %b", cur, dx.addr, rsp, e);
          end
          exp = '0;
          msk = '1;
          bb = wbase(dx.addr);
          if (!dx.wr && !e) begin
            for (int b = 0; b < 8; b++) begin
              exp[8*b +: 8] = mdl[cur][bb+b];
              msk[8*b +: 8] = known[cur][bb+b] ? 8'hFF : 8'h00;
            end
          end
          checks++;
          if ((rd & msk) !== (exp & msk)) begin
            fails++;
            $display("FAIL rdata dut%0d a=%h: got %h need %h mask %h",
                     cur, dx.addr, rd, exp, msk);
          end
          if (dx.wr && !e) begin
            for (int b = 0; b < 8; b++) begin
              if (dx.strb[b]) begin
                mdl[cur][bb+b]   = dx.wdata[8*b +: 8];
                known[cur][bb+b] = 1'b1;
              end
            end
          end
          cap_rdata.push_back(rd);
          cap_waits.push_back(wcnt);
          cap_resp.push_back(rsp);
        end
      end else begin
        checks++;
        if (rdy !== 1'b1 || rsp !== 1'b0 || rd !== 64'd0) begin
          fails++;
          $display("FAIL idle_out dut%0d: rdy=%b resp=%b rdata=%h need 1 0 0",
                   cur, rdy, rsp, rd);
        end
      end
      if (last_ready) begin
        if (ai < n) begin
          ax = q[ai];
          ai++;
          haddr  = ax.addr;
          hwrite = ax.wr;
          hsize  = ax.size;
          htrans = ax.idle ? 2'b00 : 2'b10;
          hsel   = ax.sel ? (3'b001 << cur) : 3'b000;
          ap     = !ax.idle && ax.sel;
        end else begin
          htrans = 2'b00;
          hsel   = 3'b000;
          ap     = 1'b0;
        end
      end
      hwdata = dp ? dx.wdata : 64'd0;
      hwstrb = dp ? dx.strb : 8'd0;
      last_ready = rdy;
      if (ai >= n && !ap && (!dp || rdy)) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      fails++;
      $display("FAIL seq_timeout dut%0d: issued %0d of %0d", cur, ai, n);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (rdy_a !== 3'b111 || resp_a !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: rdy=%b resp=%b need 111 000", rdy_a, resp_a);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdata_a[d] !== 64'd0) begin
        fails++;
        $display("FAIL reset_rdata dut%0d: got %h need 0", d, rdata_a[d]);
      end
    end
    HRESETn = 1'b1;
  endtask

  task automatic test_write_read();
    cur = 0;
    q.delete();
    q.push_back(mk(1, 32'h10, 3'd3, 64'h1122334455667788, 8'hFF));
    q.push_back(mk(0, 32'h10, 3'd3, 64'd0, 8'h00));
    run_seq();
    checks++;
    if (cap_rdata.size() != 2 || cap_rdata[1] !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL write_read: got %h need 1122334455667788",
               cap_rdata.size() > 1 ? cap_rdata[1] : 64'd0);
    end
  endtask

  task automatic test_strobes();
    cur = 0;
    q.delete();
    q.push_back(mk(1, 32'h20, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF));
    q.push_back(mk(1, 32'h20, 3'd0, 64'hAAAAAAAAAAAAAAAA, 8'h01));
    q.push_back(mk(0, 32'h20, 3'd3, 64'd0, 8'h00));
    run_seq();
    checks++;
    if (cap_rdata.size() != 3 || cap_rdata[2] !== 64'hFFFFFFFFFFFFFFAA) begin
      fails++;
      $display("FAIL strobes: got %h need ffffffffffffffaa",
               cap_rdata.size() > 2 ? cap_rdata[2] : 64'd0);
    end
  endtask

  task automatic test_waits();
    cur = 1;
    q.delete();
    q.push_back(mk(1, 32'h40, 3'd3, 64'hCAFEF00D12345678, 8'hFF));
    q.push_back(mk(0, 32'h40, 3'd3, 64'd0, 8'h00));
    run_seq();
    checks++;
    if (cap_waits.size() != 2 || cap_waits[1] != 3 ||
        cap_rdata[1] !== 64'hCAFEF00D12345678) begin
      fails++;
      $display("FAIL waits3: waits=%0d rdata=%h need 3 cafef00d12345678",
               cap_waits.size() > 1 ? cap_waits[1] : -1,
               cap_rdata.size() > 1 ? cap_rdata[1] : 64'd0);
    end
  endtask

  task automatic test_errors();
    cur = 0;
    q.delete();
    q.push_back(mk(1, 32'h00, 3'd3, 64'h0123456789ABCDEF, 8'hFF));
    q.push_back(mk(1, 32'h02, 3'd2, 64'h5555555555555555, 8'hFF));
    q.push_back(mk(1, 32'h00, 3'd4, 64'h6666666666666666, 8'hFF));
    q.push_back(mk(0, 32'h00, 3'd3, 64'd0, 8'h00));
    run_seq();
    checks++;
    if (cap_resp.size() != 4 || cap_resp[1] !== 1'b1 || cap_resp[2] !== 1'b1 ||
        cap_waits[1] != 1 || cap_waits[2] != 1) begin
      fails++;
      $display("FAIL err_resp: n=%0d need two-cycle ERROR on misaligned and size4",
               cap_resp.size());
    end
    checks++;
    if (cap_rdata.size() != 4 || cap_rdata[3] !== 64'h0123456789ABCDEF) begin
      fails++;
      $display("FAIL err_nowrite: got %h need 0123456789abcdef",
               cap_rdata.size() > 3 ? cap_rdata[3] : 64'd0);
    end
  endtask

  task automatic test_ro();
    cur = 2;
    q.delete();
    q.push_back(mk(1, 32'h08, 3'd3, 64'h7777777777777777, 8'hFF));
    q.push_back(mk(0, 32'h08, 3'd3, 64'd0, 8'h00));
    q.push_back(mk(1, 32'h0C, 3'd2, 64'h8888888888888888, 8'h0F));
    run_seq();
    checks++;
    if (cap_resp.size() != 3 || cap_resp[0] !== 1'b1 ||
        cap_resp[1] !== 1'b0 || cap_waits[1] != 0 || cap_resp[2] !== 1'b1) begin
      fails++;
      $display("FAIL ro_resp: n=%0d need ERROR,OKAY,ERROR", cap_resp.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] x;
    logic [63:0] y;
    cur = 0;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    q.delete();
    q.push_back(mk(1, 32'h18, 3'd3, x, 8'hFF));
    q.push_back(mk(0, 32'h18, 3'd3, 64'd0, 8'h00));
    q.push_back(mk(1, 32'h1C, 3'd2, y, 8'hF0));
    q.push_back(mk(0, 32'h18, 3'd3, 64'd0, 8'h00));
    run_seq();
    checks++;
    if (cap_rdata.size() != 4 || cap_rdata[1] !== x ||
        cap_rdata[3] !== ((y & 64'hFFFFFFFF00000000) | (x & 64'h00000000FFFFFFFF))) begin
      fails++;
      $display("FAIL back_to_back: n=%0d need new data on following read",
               cap_rdata.size());
    end
  endtask

  task automatic test_reset_midwait();
    logic [63:0] a;
    a = 64'hA5A5A5A55A5A5A5A;
    cur = 1;
    q.delete();
    q.push_back(mk(1, 32'h30, 3'd3, a, 8'hFF));
    run_seq();
    haddr  = 32'h30;
    hwrite = 1'b1;
    hsize  = 3'd3;
    htrans = 2'b10;
    hsel   = 3'b010;
    @(posedge HCLK);
    #1;
    htrans = 2'b00;
    hsel   = 3'b000;
    hwdata = 64'h0BADC0DE0BADC0DE;
    hwstrb = 8'hFF;
    checks++;
    if (rdy_a[1] !== 1'b0) begin
      fails++;
      $display("FAIL midwait_enter: rdy=%b need 0", rdy_a[1]);
    end
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (rdy_a[1] !== 1'b1 || resp_a[1] !== 1'b0 || rdata_a[1] !== 64'd0) begin
      fails++;
      $display("FAIL midwait_reset: rdy=%b resp=%b rdata=%h need 1 0 0",
               rdy_a[1], resp_a[1], rdata_a[1]);
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    hwdata = '0;
    hwstrb = '0;
    q.delete();
    q.push_back(mk(0, 32'h30, 3'd3, 64'd0, 8'h00));
    run_seq();
    checks++;
    if (cap_rdata.size() != 1 || cap_rdata[0] !== a) begin
      fails++;
      $display("FAIL midwait_nowrite: got %h need %h",
               cap_rdata.size() > 0 ? cap_rdata[0] : 64'd0, a);
    end
  endtask

  task automatic test_random();
    xfer_t t;
    int    r;
    for (int d = 0; d < 3; d++) begin
      cur = d;
      q.delete();
      if (!ro_of[d]) begin
        for (int w = 0; w < NW; w++) begin
          q.push_back(mk(1, 32'(w * 8), 3'd3, {$urandom, $urandom}, 8'hFF));
        end
      end
      for (int i = 0; i < 80; i++) begin
        r = $urandom_range(0, 99);
        t.idle = (r < 12);
        t.sel  = !(r >= 12 && r < 17);
        if ($urandom_range(0, 9) == 0) t.size = 3'($urandom_range(4, 7));
        else t.size = 3'($urandom_range(0, 3));
        t.addr = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 1);
        t.wr    = 1'($urandom_range(0, 1));
        t.wdata = {$urandom, $urandom};
        t.strb  = 8'($urandom);
        q.push_back(t);
      end
      run_seq();
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int b = 0; b < NBY; b++) begin
        mdl[d][b]   = 8'h00;
        known[d][b] = 1'b0;
      end
    end
    test_reset();
    test_write_read();
    test_strobes();
    test_waits();
    test_errors();
    test_ro();
    test_back_to_back();
    test_reset_midwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
